// File: rtl/draw_rect_ctl.sv
// Motion controller feeding draw_rect: mouse tracking in IDLE, gravity fall on click.
// Define DRAW_RECT_CTL_BOUNCE_EN to add a damped bounce at the floor (BOUNCE/RISE states).
module draw_rect_ctl #(
  parameter int unsigned RECT_WIDTH  = 200,
  parameter int unsigned RECT_HEIGHT = 100,
  parameter int unsigned MAX_X_POS   = 800,
  parameter int unsigned MAX_Y_POS   = 600,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned VMAX        = 32
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling
);

  localparam int unsigned XLIM  = MAX_X_POS - 1 - RECT_WIDTH;
  localparam int unsigned FLOOR = MAX_Y_POS - 1 - RECT_HEIGHT;
  localparam logic [11:0] XLIM_V  = 12'(XLIM);
  localparam logic [11:0] FLOOR_V = 12'(FLOOR);
  localparam logic [5:0]  GRAV_V  = 6'(GRAVITY);
  localparam logic [12:0] VMAX_V  = 13'(VMAX);

`ifdef DRAW_RECT_CTL_BOUNCE_EN
  typedef enum logic [2:0] {S_IDLE, S_FALL, S_LANDED, S_BOUNCE, S_RISE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FALL, S_LANDED} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic        r_vblnk_d, r_left_d, r_falling;
  logic [5:0]  r_vel, w_vel_nxt;
  logic [11:0] r_xpos, r_ypos, w_xpos_nxt, w_ypos_nxt;
  logic        w_tick, w_click;
  logic [12:0] w_vel_inc, w_vel_sat, w_ysum;

  assign w_tick    = vblnk & ~r_vblnk_d;
  assign w_click   = mouse_left & ~r_left_d;
  assign w_vel_inc = 13'(r_vel) + 13'(GRAV_V);
  assign w_vel_sat = (w_vel_inc > VMAX_V) ? VMAX_V : w_vel_inc;
  assign w_ysum    = 13'(r_ypos) + w_vel_sat;

`ifdef DRAW_RECT_CTL_BOUNCE_EN
  logic [5:0]  w_vel_dmp, w_vel_dec;
  logic [11:0] w_yrise;
  assign w_vel_dmp = r_vel - (r_vel >> 2);
  assign w_vel_dec = r_vel - GRAV_V;
  // Rising past the top edge pins the box at row 0.
  assign w_yrise   = (12'(w_vel_dec) > r_ypos) ? 12'd0 : (r_ypos - 12'(w_vel_dec));
`endif

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_vel_nxt   = r_vel;
    w_xpos_nxt  = r_xpos;
    w_ypos_nxt  = r_ypos;
    case (r_state)
      S_IDLE: begin
        w_xpos_nxt = (mouse_xpos > XLIM_V)  ? XLIM_V  : mouse_xpos;
        w_ypos_nxt = (mouse_ypos > FLOOR_V) ? FLOOR_V : mouse_ypos;
        if (w_click) begin
          w_state_nxt = S_FALL;
          w_vel_nxt   = '0;
        end
      end
      S_FALL: begin
        if (w_tick) begin
          w_vel_nxt = 6'(w_vel_sat);
          if (w_ysum >= 13'(FLOOR_V)) begin
            w_ypos_nxt = FLOOR_V;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            w_state_nxt = S_BOUNCE;
`else
            w_state_nxt = S_LANDED;
`endif
          end else begin
            w_ypos_nxt = 12'(w_ysum);
          end
        end
      end
      S_LANDED: begin
        if (w_click) w_state_nxt = S_IDLE;
      end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
      S_BOUNCE: begin
        if (w_vel_dmp < 6'd2) begin
          w_vel_nxt   = '0;
          w_state_nxt = S_LANDED;
        end else begin
          w_vel_nxt   = w_vel_dmp;
          w_state_nxt = S_RISE;
        end
      end
      S_RISE: begin
        if (w_tick) begin
          if (r_vel <= GRAV_V) begin
            w_vel_nxt   = '0;
            w_state_nxt = S_FALL;
          end else begin
            w_vel_nxt  = w_vel_dec;
            w_ypos_nxt = w_yrise;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and edge-detect registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vel     <= '0;
      r_xpos    <= '0;
      r_ypos    <= '0;
      r_falling <= 1'b0;
      r_vblnk_d <= 1'b0;
      r_left_d  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vel     <= w_vel_nxt;
      r_xpos    <= w_xpos_nxt;
      r_ypos    <= w_ypos_nxt;
      r_falling <= (w_state_nxt != S_IDLE);
      r_vblnk_d <= vblnk;
      r_left_d  <= mouse_left;
    end
  end

  assign xpos    = r_xpos;
  assign ypos    = r_ypos;
  assign falling = r_falling;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl: a cycle model pushes expected outputs, the monitor pops and compares.
module tb_draw_rect_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        falling;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int x;
    int y;
    int f;
  } exp_t;
  exp_t sb_q[$];

  // model state: 0 IDLE, 1 FALL, 2 LANDED, 3 BOUNCE, 4 RISE
  int m_st, m_vel, m_x, m_y;
  bit m_vb_d, m_ml_d;

  draw_rect_ctl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_left (mouse_left),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .xpos       (xpos),
    .ypos       (ypos),
    .falling    (falling)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int v, s, vd;
    bit tk, ck;
    if (rst) begin
      m_st = 0; m_vel = 0; m_x = 0; m_y = 0; m_vb_d = 0; m_ml_d = 0;
    end else begin
      tk = vblnk && !m_vb_d;
      ck = mouse_left && !m_ml_d;
      case (m_st)
        0: begin
          m_x = (int'(mouse_xpos) > 599) ? 599 : int'(mouse_xpos);
          m_y = (int'(mouse_ypos) > 499) ? 499 : int'(mouse_ypos);
          if (ck) begin m_st = 1; m_vel = 0; end
        end
        1: if (tk) begin
          v = m_vel + 1;
          if (v > 32) v = 32;
          m_vel = v;
          s = m_y + v;
          if (s >= 499) begin
            m_y = 499;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            m_st = 3;
`else
            m_st = 2;
`endif
          end else m_y = s;
        end
        2: if (ck) m_st = 0;
        3: begin
          vd = m_vel - m_vel / 4;
          if (vd < 2) begin m_vel = 0; m_st = 2; end
          else begin m_vel = vd; m_st = 4; end
        end
        4: if (tk) begin
          if (m_vel <= 1) begin m_vel = 0; m_st = 1; end
          else begin
            m_vel = m_vel - 1;
            m_y = m_y - m_vel;
            if (m_y < 0) m_y = 0;
          end
        end
        default: m_st = 0;
      endcase
      m_vb_d = vblnk;
      m_ml_d = mouse_left;
    end
  endtask

  // One clock: model predicts, DUT edge, compare after the edge, return on negedge.
  task automatic cyc();
    exp_t e;
    model_step();
    e.x = m_x; e.y = m_y; e.f = (m_st != 0) ? 1 : 0;
    sb_q.push_back(e);
    @(posedge pclk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_xpos", int'(xpos), e.x);
    check_eq("sb_ypos", int'(ypos), e.y);
    check_eq("sb_falling", int'(falling), e.f);
    @(negedge pclk);
  endtask

  task automatic frame(input int hold);
    vblnk = 1'b1;
    for (int k = 0; k < hold; k++) cyc();
    vblnk = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic click();
    mouse_left = 1'b1;
    cyc();
    mouse_left = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y;
    rst = 1'b1; vblnk = 1'b0; mouse_left = 1'b0;
    mouse_xpos = 12'd300; mouse_ypos = 12'd300;

    // reset
    cyc();
    cyc();
    check_eq("rst_x", int'(xpos), 0);
    check_eq("rst_y", int'(ypos), 0);
    check_eq("rst_falling", int'(falling), 0);
    rst = 1'b0;
    cyc();
    check_eq("post_rst_x", int'(xpos), 300);
    check_eq("post_rst_y", int'(ypos), 300);

    // tracking and clamping
    mouse_xpos = 12'd100; mouse_ypos = 12'd50;
    cyc();
    check_eq("trk_x", int'(xpos), 100);
    check_eq("trk_y", int'(ypos), 50);
    mouse_xpos = 12'd700; mouse_ypos = 12'd590;
    cyc();
    check_eq("clamp_x", int'(xpos), 599);
    check_eq("clamp_y", int'(ypos), 499);

    // fall from (100,0)
    mouse_xpos = 12'd100; mouse_ypos = 12'd0;
    click();
    check_eq("fall_start_y", int'(ypos), 0);
    check_eq("fall_start_falling", int'(falling), 1);
    mouse_xpos = 12'd400; mouse_ypos = 12'd400;
    for (int n = 1; n <= 32; n++) begin
      frame((n == 10) ? 4 : 1);
      exp_y = n * (n + 1) / 2;
      if (exp_y > 499) exp_y = 499;
      check_eq("fall_y", int'(ypos), exp_y);
      check_eq("fall_x", int'(xpos), 100);
      if (n == 5) begin
        click();
        check_eq("fall_click_ignored", int'(falling), 1);
      end
    end
    check_eq("tick31_32_floor", int'(ypos), 499);

`ifdef DRAW_RECT_CTL_BOUNCE_EN
    cyc();
    frame(1);
    check_eq("rise1_y", int'(ypos), 476);
`endif
    for (int f = 0; f < 400 && m_st != 2; f++) frame(1);
    check_eq("landed_state", m_st, 2);
    check_eq("landed_y", int'(ypos), 499);
    check_eq("landed_falling", int'(falling), 1);

    // click in LANDED returns to IDLE
    mouse_xpos = 12'd20; mouse_ypos = 12'd20;
    mouse_left = 1'b1;
    cyc();
    check_eq("landed_click_falling", int'(falling), 0);
    mouse_left = 1'b0;
    cyc();
    check_eq("resume_x", int'(xpos), 20);
    check_eq("resume_y", int'(ypos), 20);

    // click and tick in the same IDLE cycle
    mouse_xpos = 12'd50; mouse_ypos = 12'd10;
    cyc();
    mouse_left = 1'b1; vblnk = 1'b1;
    cyc();
    mouse_left = 1'b0; vblnk = 1'b0;
    cyc();
    cyc();
    check_eq("same_cycle_y", int'(ypos), 10);
    check_eq("same_cycle_falling", int'(falling), 1);
    frame(1);
    check_eq("first_step_y", int'(ypos), 11);

    // reset mid-fall
    frame(1);
    frame(1);
    rst = 1'b1;
    cyc();
    check_eq("midfall_rst_y", int'(ypos), 0);
    check_eq("midfall_rst_falling", int'(falling), 0);
    rst = 1'b0;
    mouse_xpos = 12'd30; mouse_ypos = 12'd40;
    cyc();
    check_eq("after_rst_x", int'(xpos), 30);
    check_eq("after_rst_y", int'(ypos), 40);
    check_eq("after_rst_falling", int'(falling), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
